dmi_jtag_host: RTL and testbench



---
 rtl/dmi_jtag_host_pkg.sv | 26 ++
 rtl/jtag_tck_gen.sv | 53 +++++
 rtl/dmi_jtag_host.sv | 164 ++++++++++++++++
 tb/tb_dmi_jtag_host.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_jtag_host_pkg.sv
// Shared types and TMS sequences for the host-side JTAG scan engine.
// TMS constants are stored LSB first: bit n is driven during TCK cycle n of that phase.
package dmi_jtag_host_pkg;

  typedef enum logic [1:0] {
    OpReset = 2'd0,
    OpIr    = 2'd1,
    OpDr    = 2'd2,
    OpRsvd  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StIdle  = 3'd1,
    StTrst  = 3'd2,
    StEntry = 3'd3,
    StShift = 3'd4,
    StExit  = 3'd5,
    StResp  = 3'd6
  } state_e;

  localparam logic [5:0] ResetTms   = 6'b011111;
  localparam logic [2:0] DrEntryTms = 3'b001;
  localparam logic [3:0] IrEntryTms = 4'b0011;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: a low phase then a high phase of ClkDiv clk_i cycles each, idling low.
// The strobes flag the cycle before the edge, so registers loaded on them change together with tck_o.
module jtag_tck_gen #(
  parameter int ClkDiv = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tck_o,
  output logic fall_strobe_o,
  output logic rise_strobe_o,
  output logic cycle_done_o
);
  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            phase_end;

  assign phase_end = enable_i && (cnt_q == CntLast);

  // Dropping enable parks the divider at the start of a low phase.
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!enable_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (phase_end) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o         = tck_q;
  assign rise_strobe_o = phase_end && !tck_q;
  assign fall_strobe_o = phase_end && tck_q;
  assign cycle_done_o  = phase_end && tck_q;

endmodule

// File: rtl/dmi_jtag_host.sv
// Host JTAG scan engine: one TAP reset / IR scan / DR scan per request, captured TDO returned.
// valid/ready: a transfer happens on a rising clk_i edge with both high; the sender holds its payload until then.
module dmi_jtag_host
  import dmi_jtag_host_pkg::*;
#(
  parameter int MaxLen = 64,
  parameter int ClkDiv = 2,
  localparam int LenW = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [LenW-1:0]   req_len_i,
  input  logic [MaxLen-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  output logic              trst_no,
  output logic [2:0]        dbg_state_o
);
  localparam int IdxW = $clog2(MaxLen);
  localparam logic [LenW-1:0] MaxLenL = LenW'(MaxLen);

  state_e            state_q, state_d;
  op_e               op_q, op_d, req_op;
  logic [LenW-1:0]   n_q, n_d, len_q, len_d;
  logic [MaxLen-1:0] data_q, data_d, rsp_q, rsp_d;
  logic              err_q, err_d, trst_q;
  logic              tms_q, tms_d, tdi_q, tdi_d;
  logic              tck_en, fall, rise, done, illegal;

  function automatic logic [LenW-1:0] last_of(state_e st, op_e op, logic [LenW-1:0] len);
    case (st)
      StInit, StTrst: last_of = LenW'(5);
      StEntry:        last_of = (op == OpIr) ? LenW'(3) : LenW'(2);
      StShift:        last_of = len - LenW'(1);
      StExit:         last_of = LenW'(1);
      default:        last_of = '0;
    endcase
  endfunction

  assign req_op  = op_e'(req_op_i);
  assign illegal = (req_op == OpRsvd) ||
                   ((req_op != OpReset) && ((req_len_i == '0) || (req_len_i > MaxLenL)));
  assign tck_en  = (state_q == StInit) || (state_q == StTrst) || (state_q == StEntry) ||
                   (state_q == StShift) || (state_q == StExit);

  jtag_tck_gen #(.ClkDiv(ClkDiv)) u_tck (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (tck_en),
    .tck_o         (tck_o),
    .fall_strobe_o (fall),
    .rise_strobe_o (rise),
    .cycle_done_o  (done)
  );

  // n_q counts TCK cycles within the current phase; the phase ends on its last cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d   = req_op;
          len_d  = req_len_i;
          data_d = req_data_i;
          rsp_d  = '0;
          err_d  = illegal;
          n_d    = '0;
          if (illegal)                state_d = StResp;
          else if (req_op == OpReset) state_d = StTrst;
          else                        state_d = StEntry;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: begin
        if ((state_q == StShift) && rise) rsp_d[n_q[IdxW-1:0]] = tdo_i;
        if (done) begin
          if (n_q == last_of(state_q, op_q, len_q)) begin
            n_d = '0;
            case (state_q)
              StInit:  state_d = StIdle;
              StEntry: state_d = StShift;
              StShift: state_d = StExit;
              default: state_d = StResp;
            endcase
          end else begin
            n_d = n_q + LenW'(1);
          end
        end
      end
    endcase
  end

  // Pin values for the TCK cycle that starts at the next edge.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      StInit, StTrst: tms_d = ResetTms[n_d[2:0]];
      StEntry:        tms_d = (op_d == OpIr) ? IrEntryTms[n_d[1:0]] : DrEntryTms[n_d[1:0]];
      StShift: begin
        tms_d = (n_d == last_of(StShift, op_d, len_d));
        tdi_d = data_d[n_d[IdxW-1:0]];
      end
      StExit:         tms_d = (n_d == '0);
      default:        ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      n_q     <= '0;
      op_q    <= OpReset;
      len_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      trst_q  <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      op_q    <= op_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      trst_q  <= 1'b1;
      // Pins move only as TCK falls, or as a command launches from idle with TCK already low.
      if (fall || (state_q == StIdle)) begin
        tms_q <= tms_d;
        tdi_q <= tdi_d;
      end
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = rsp_q;
  assign rsp_err_o   = err_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign trst_no     = trst_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Bench for dmi_jtag_host: instance 0 (ClkDiv=2) drives a behavioural DMI TAP,
// instance 1 (ClkDiv=3) has TDO looped back from TDI.
module tb_dmi_jtag_host;
  import dmi_jtag_host_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = 2'b00;
  logic        rsp_ready = 1'b0;
  logic [1:0]  req_op    = 2'd0;
  logic [6:0]  req_len   = 7'd0;
  logic [63:0] req_data  = 64'd0;

  logic [1:0]  req_ready, rsp_valid, rsp_err, tck, tms, tdi, trst;
  logic [63:0] rsp_data [2];
  logic [2:0]  dbg0, dbg1;
  logic        tap_tdo = 1'b0;

  dmi_jtag_host #(.MaxLen(64), .ClkDiv(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_op_i(req_op), .req_len_i(req_len), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[0]),
    .rsp_err_o(rsp_err[0]), .tck_o(tck[0]), .tms_o(tms[0]), .tdi_o(tdi[0]),
    .tdo_i(tap_tdo), .trst_no(trst[0]), .dbg_state_o(dbg0)
  );

  dmi_jtag_host #(.MaxLen(64), .ClkDiv(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_op_i(req_op), .req_len_i(req_len), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[1]),
    .rsp_err_o(rsp_err[1]), .tck_o(tck[1]), .tms_o(tms[1]), .tdi_o(tdi[1]),
    .tdo_i(tdi[1]), .trst_no(trst[1]), .dbg_state_o(dbg1)
  );

  // ---------------- DMI TAP model (IR 5 bits, IDCODE=0x1, capture 00101) ----------------
  typedef enum int {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_e;
  tap_e        tap_st  = TLR;
  logic [4:0]  tap_ir  = 5'h01;
  logic [63:0] tap_sr  = 64'd0;
  int          tap_len = 1;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck[0] or negedge trst[0]) begin
    if (!trst[0]) begin
      tap_st <= TLR;
      tap_ir <= 5'h01;
    end else begin
      case (tap_st)
        TLR:  tap_ir <= 5'h01;
        CDR:  begin tap_sr <= (tap_ir == 5'h01) ? 64'h1 : 64'h0; tap_len <= (tap_ir == 5'h01) ? 32 : 1; end
        CIR:  begin tap_sr <= 64'h5; tap_len <= 5; end
        SHDR, SHIR: tap_sr <= (tap_sr >> 1) | ({63'd0, tdi[0]} << (tap_len - 1));
        UIR:  tap_ir <= tap_sr[4:0];
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms[0]);
    end
  end

  always @(negedge tck[0]) tap_tdo <= ((tap_st == SHDR) || (tap_st == SHIR)) ? tap_sr[0] : 1'b0;

  // ---------------- pin monitor ----------------
  int          rises [2]    = '{0, 0};
  int          rise0 [2]    = '{0, 0};
  int          gap_cnt [2]  = '{0, 0};
  int          last_gap [2] = '{0, 0};
  int          stab_bad     = 0;
  logic [15:0] tms_hist     = 16'd0;
  logic [1:0]  tck_prev = 2'b00, tms_prev = 2'b00, tdi_prev = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      gap_cnt[i]++;
      if (tck[i] && !tck_prev[i]) begin
        rises[i]++;
        last_gap[i] = gap_cnt[i];
        gap_cnt[i]  = 0;
        if (i == 0) tms_hist = {tms_hist[14:0], tms[0]};
      end
      if (tck[i] && ((tms[i] !== tms_prev[i]) || (tdi[i] !== tdi_prev[i]))) stab_bad++;
    end
    tck_prev = tck;
    tms_prev = tms;
    tdi_prev = tdi;
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int inst, input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
    int cyc;
    @(negedge clk);
    req_op = op; req_len = len; req_data = data; req_valid[inst] = 1'b1;
    cyc = 0;
    while (!req_ready[inst] && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("accept_timeout", 64'(cyc < 2000), 64'd1);
    rise0[inst] = rises[inst];
    @(negedge clk);
    req_valid[inst] = 1'b0;
  endtask

  task automatic recv(input int inst, input int exp_tcks, input int exp_lat, input int hold);
    int cyc, bad;
    logic [64:0] exp;
    logic [63:0] held;
    cyc = 0;
    while (!rsp_valid[inst] && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("rsp_timeout", 64'(cyc < 2000), 64'd1);
    if (exp_lat >= 0) chk("rsp_latency", 64'(cyc), 64'(exp_lat));
    exp = exp_q.pop_front();
    chk("rsp_data", rsp_data[inst], exp[63:0]);
    chk("rsp_err", 64'(rsp_err[inst]), 64'(exp[64]));
    chk("tck_count", 64'(rises[inst] - rise0[inst]), 64'(exp_tcks));
    held = rsp_data[inst];
    bad  = 0;
    repeat (hold) begin
      @(negedge clk);
      if ((rsp_data[inst] !== held) || (req_ready[inst] !== 1'b0) ||
          (tck[inst] !== 1'b0) || (rsp_valid[inst] !== 1'b1)) bad++;
    end
    if (hold > 0) chk("rsp_hold_stable", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", 64'(req_ready[inst]), 64'd1);
  endtask

  task automatic wait_init(input string tag);
    int cyc, vseen, r0;
    r0 = rises[0];
    cyc = 0;
    vseen = 0;
    while (!req_ready[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid[0]) vseen++;
    end
    chk({tag, "_timeout"}, 64'(cyc < 200), 64'd1);
    chk({tag, "_no_rsp"}, 64'(vseen), 64'd0);
    chk({tag, "_tck_count"}, 64'(rises[0] - r0), 64'd6);
    chk({tag, "_tms_seq"}, 64'(tms_hist[5:0]), 64'(6'b111110));
    chk({tag, "_trst"}, 64'(trst[0]), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] d, mask;
    int len, cyc;

    repeat (3) @(negedge clk);
    chk("reset_pins0", 64'({tck[0], tms[0], tdi[0], trst[0], req_ready[0], rsp_valid[0], rsp_err[0]}), 64'(7'b0100000));
    chk("reset_pins1", 64'({tck[1], tms[1], tdi[1], trst[1], req_ready[1], rsp_valid[1], rsp_err[1]}), 64'(7'b0100000));
    chk("reset_data", rsp_data[0], 64'd0);
    chk("reset_state", 64'(dbg0), 64'(StInit));
    rst = 1'b0;
    wait_init("init");
    chk("init_tck_period", 64'(last_gap[0]), 64'd4);
    chk("idle_state", 64'(dbg0), 64'(StIdle));

    // IR capture pattern, then IDCODE
    exp_q.push_back({1'b0, 64'h5});
    send(0, OpIr, 7'd5, 64'h01);
    recv(0, 11, -1, 0);
    exp_q.push_back({1'b0, 64'h1});
    send(0, OpDr, 7'd32, 64'h0);
    recv(0, 37, -1, 0);

    // bypass: one-bit delay, first captured bit is 0
    exp_q.push_back({1'b0, 64'h5});
    send(0, OpIr, 7'd5, 64'h1f);
    recv(0, 11, -1, 0);
    exp_q.push_back({1'b0, 64'h4A});
    send(0, OpDr, 7'd8, 64'hA5);
    recv(0, 13, -1, 10);

    // illegal commands: immediate error response, no TCK
    exp_q.push_back({1'b1, 64'h0});
    send(0, OpDr, 7'd0, 64'hFF);
    recv(0, 0, 0, 0);
    exp_q.push_back({1'b1, 64'h0});
    send(0, OpRsvd, 7'd5, 64'hFF);
    recv(0, 0, 0, 0);
    exp_q.push_back({1'b1, 64'h0});
    send(0, OpIr, 7'd65, 64'hFF);
    recv(0, 0, 0, 0);

    // TAP reset op
    exp_q.push_back({1'b0, 64'h0});
    send(0, OpReset, 7'd1, 64'h0);
    recv(0, 6, -1, 0);
    chk("trst_op_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));

    // ClkDiv=3 loopback: captured bits equal TDI bits, upper bits masked
    exp_q.push_back({1'b0, 64'h3C});
    send(1, OpDr, 7'd8, 64'hFFFF_FFFF_FFFF_FF3C);
    recv(1, 13, -1, 0);
    chk("div3_tck_period", 64'(last_gap[1]), 64'd6);
    exp_q.push_back({1'b0, 64'h15});
    send(1, OpIr, 7'd5, 64'h15);
    recv(1, 11, -1, 0);
    for (int i = 0; i < 3; i++) begin
      len  = $urandom_range(1, 64);
      d    = {$urandom, $urandom};
      mask = (len == 64) ? '1 : ((64'd1 << len) - 64'd1);
      exp_q.push_back({1'b0, d & mask});
      send(1, OpDr, 7'(len), d);
      recv(1, len + 5, -1, 0);
    end

    // reset in the middle of a 40-bit DR shift
    send(0, OpDr, 7'd40, {$urandom, $urandom});
    cyc = 0;
    while ((rises[0] - rise0[0]) < 10 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("midscan_reach_shift", 64'(dbg0), 64'(StShift));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midscan_reset_pins", 64'({tck[0], tms[0], tdi[0], trst[0], req_ready[0], rsp_valid[0], rsp_err[0]}), 64'(7'b0100000));
    chk("midscan_reset_data", rsp_data[0], 64'd0);
    rst = 1'b0;
    wait_init("reinit");
    exp_q.push_back({1'b0, 64'h1});
    send(0, OpDr, 7'd32, 64'h0);
    recv(0, 37, -1, 0);

    chk("tms_tdi_stable_while_tck_high", 64'(stab_bad), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
